// File: rtl/nn_pwl_pkg.sv
// Shared definitions for the piecewise-linear interpolation pipe.
//
// Contents:
//   DATA_W, ADDR_W, FRAC_W    sample / table-address / fraction widths
//   data_t   signed sample        diff_t  signed segment slope (DATA_W+1)
//   prod_t   signed slope*frac    sum_t   signed pre-clamp result
//   SAT_MAX / SAT_MIN         saturation limits of data_t
//   sat_data()                clamp a sum_t into data_t
package nn_pwl_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int FRAC_W = DATA_W - ADDR_W;
    localparam int DIFF_W = DATA_W + 1;
    // |diff| <= 2^DATA_W - 1 and frac <= 2^FRAC_W - 1, so DIFF_W+FRAC_W bits hold the product.
    localparam int PROD_W = DIFF_W + FRAC_W;
    // base plus shifted product needs two guard bits over DATA_W.
    localparam int SUM_W  = DATA_W + 2;

    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic signed [DIFF_W-1:0] diff_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [SUM_W-1:0]  sum_t;
    typedef logic        [ADDR_W-1:0] addr_t;
    typedef logic        [FRAC_W-1:0] frac_t;

    localparam data_t SAT_MAX = data_t'(127);
    localparam data_t SAT_MIN = data_t'(-128);

    function automatic data_t sat_data(input sum_t v);
        if (v > sum_t'(SAT_MAX)) begin
            return SAT_MAX;
        end else if (v < sum_t'(SAT_MIN)) begin
            return SAT_MIN;
        end else begin
            return data_t'(v);
        end
    endfunction

endpackage

// File: rtl/pwl_interp_pipe_if.sv
// Handshake and lookup-table bus of pwl_interp_pipe.
//
// Signals:
//   in_valid/in_ready/in_data      upstream sample stream
//   lut_address/lut_base/lut_next  activation-table port (combinational reply)
//   out_valid/out_ready/out_data   downstream result stream
// Modports:
//   slave   the interpolation pipe itself
//   master  the environment (producer, table and consumer)
interface pwl_interp_pipe_if;
    import nn_pwl_pkg::*;

    logic  in_valid;
    logic  in_ready;
    data_t in_data;
    addr_t lut_address;
    data_t lut_base;
    data_t lut_next;
    logic  out_valid;
    logic  out_ready;
    data_t out_data;

    modport slave (
        input  in_valid, in_data, lut_base, lut_next, out_ready,
        output in_ready, lut_address, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, lut_base, lut_next, out_ready,
        input  in_ready, lut_address, out_valid, out_data
    );

endinterface

// File: rtl/pwl_interp_pipe_lerp.sv
// pwl_lerp: combinational interpolation arithmetic.
//   y = clamp(base + ((diff * frac) [+ 2^(FRAC_W-1)]) >>> FRAC_W)
//
// Ports:
//   i_base  signed table value at the segment start
//   i_diff  signed slope to the next segment (next - base)
//   i_frac  unsigned position inside the segment
//   o_y     signed, saturated result
//
// Build option: define NN_PWL_ROUND_EN for round-half-up; otherwise the shift
// floors and no rounding adder exists.
module pwl_lerp
    import nn_pwl_pkg::*;
(
    input  data_t i_base,
    input  diff_t i_diff,
    input  frac_t i_frac,
    output data_t o_y
);

    prod_t w_frac_ext;
    prod_t w_prod;
    prod_t w_prod_adj;
    prod_t w_shift;
    sum_t  w_sum;

    // Fraction is unsigned: zero-extend before the signed multiply.
    assign w_frac_ext = prod_t'({1'b0, i_frac});
    assign w_prod     = prod_t'(i_diff) * w_frac_ext;

`ifdef NN_PWL_ROUND_EN
    localparam prod_t ROUND_HALF = prod_t'(1 << (FRAC_W - 1));
    assign w_prod_adj = w_prod + ROUND_HALF;
`else
    assign w_prod_adj = w_prod;
`endif

    assign w_shift = w_prod_adj >>> FRAC_W;
    // The shifted product fits in SUM_W bits, so the truncating cast is lossless.
    assign w_sum   = sum_t'(i_base) + sum_t'(w_shift);
    assign o_y     = sat_data(w_sum);

endmodule

// File: rtl/pwl_interp_pipe.sv
// pwl_interp_pipe: pipelined piecewise-linear interpolation for the activation path.
//
// Stages (each with its own valid bit, ready chain collapses bubbles):
//   S1   registers the sample; its upper bits address the table
//   S2   registers table base, slope (next - base) and fraction
//   S3   registers the interpolated, clamped result
//   OUT  output register presented to the consumer
// A sample accepted at edge k is presented after edge k+3.
//
// Ports:
//   clk   single clock
//   rst   synchronous, active-high reset
//   bus   pwl_interp_pipe_if.slave (sample in, table port, result out)
//
// Build option: NN_PWL_ROUND_EN selects round-half-up in pwl_lerp.
module pwl_interp_pipe
    import nn_pwl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    pwl_interp_pipe_if.slave        bus
);

    localparam int NSTG = 4;    // S1, S2, S3, OUT

    logic [NSTG-1:0] r_valid;
    logic [NSTG-1:0] w_ready;
    logic [NSTG-1:0] w_valid_in;

    data_t r_s1_x;
    data_t r_s2_base;
    diff_t r_s2_diff;
    frac_t r_s2_frac;
    data_t r_s3_y;
    data_t r_out_data;

    diff_t w_diff;
    data_t w_y;

    assign w_valid_in = {r_valid[NSTG-2:0], bus.in_valid};

    // Stage gi may load when it or any later stage is empty, or the consumer
    // takes the output this cycle. Written as a flat reduction so the chain has
    // no self-referencing vector.
    genvar gi;
    generate
        for (gi = 0; gi < NSTG; gi++) begin : g_ready
            assign w_ready[gi] = bus.out_ready || !(&r_valid[NSTG-1:gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < NSTG; i++) begin
                if (w_ready[i]) begin
                    r_valid[i] <= w_valid_in[i];
                end
            end
        end
    end

    assign w_diff = diff_t'(bus.lut_next) - diff_t'(bus.lut_base);

    pwl_lerp u_lerp (
        .i_base (r_s2_base),
        .i_diff (r_s2_diff),
        .i_frac (r_s2_frac),
        .o_y    (w_y)
    );

    // Data registers only move when their stage loads a valid item, so the
    // table address and every data register hold during stalls and bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_x     <= '0;
            r_s2_base  <= '0;
            r_s2_diff  <= '0;
            r_s2_frac  <= '0;
            r_s3_y     <= '0;
            r_out_data <= '0;
        end else begin
            if (w_ready[0] && w_valid_in[0]) begin
                r_s1_x <= bus.in_data;
            end
            if (w_ready[1] && w_valid_in[1]) begin
                r_s2_base <= bus.lut_base;
                r_s2_diff <= w_diff;
                r_s2_frac <= r_s1_x[FRAC_W-1:0];
            end
            if (w_ready[2] && w_valid_in[2]) begin
                r_s3_y <= w_y;
            end
            if (w_ready[3] && w_valid_in[3]) begin
                r_out_data <= r_s3_y;
            end
        end
    end

    assign bus.in_ready    = w_ready[0];
    assign bus.lut_address = r_s1_x[DATA_W-1:FRAC_W];
    assign bus.out_valid   = r_valid[NSTG-1];
    assign bus.out_data    = r_out_data;

endmodule

// File: tb/tb_pwl_interp_pipe.sv
// Testbench for pwl_interp_pipe: table model, behavioural result model with a
// scoreboard queue, directed cases and a randomized stream.
module tb_pwl_interp_pipe;
    import nn_pwl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pwl_interp_pipe_if bus();

    pwl_interp_pipe dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int stale_seen = 0;

    // Table model: 0 = array table, 1 = fixed reply base 10 / next 13.
    logic signed [7:0] tab [16];
    int tab_mode = 0;

    assign bus.lut_base = (tab_mode == 1) ? 8'sd10 : tab[bus.lut_address];
    assign bus.lut_next = (tab_mode == 1) ? 8'sd13 :
                          (bus.lut_address == 4'd7) ? tab[7] : tab[bus.lut_address + 4'd1];

    // Consumer: 0 always ready, 1 pattern 1,0,0, 2 never ready, 3 random.
    int or_mode = 0;
    int or_cnt  = 0;
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = (or_cnt % 3 == 0);
                2: bus.out_ready = 1'b0;
                default: bus.out_ready = ($urandom_range(0, 1) == 1);
            endcase
            or_cnt++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Result model: segment from the top bits, linear blend from the low bits,
    // floor (or round half up) division by 16, then saturation.
    function automatic int model_y(input logic [7:0] x);
        int a, f, b, n, p, q, y;
        a = int'(x[7:4]);
        f = int'(x[3:0]);
        if (tab_mode == 1) begin
            b = 10;
            n = 13;
        end else begin
            b = int'(tab[a]);
            n = (a == 7) ? int'(tab[7]) : int'(tab[(a + 1) % 16]);
        end
        p = (n - b) * f;
`ifdef NN_PWL_ROUND_EN
        p = p + 8;
`endif
        q = (p >= 0) ? (p / 16) : -((-p + 15) / 16);   // floor(p/16)
        y = b + q;
        if (y > 127)  y = 127;
        if (y < -128) y = -128;
        return y;
    endfunction

    int exp_q [$];
    logic  prev_hold = 1'b0;
    data_t prev_data = '0;

    // Single compare process: scoreboard, stall stability, stale detection.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("stall_valid", int'(bus.out_valid), 1);
                check("stall_data", int'(bus.out_data), int'(prev_data));
            end
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("stale_output", int'(bus.out_data), 9999);
                end else begin
                    check("out_data", int'(bus.out_data), exp_q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model_y(bus.in_data));
            end
            prev_hold = bus.out_valid && !bus.out_ready;
            prev_data = bus.out_data;
        end
    end

    task automatic send(input logic [7:0] x, output int waited);
        waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 300) begin
                check("send_timeout", waited, 0);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int t = 0;
        while (t < 100) begin
            @(negedge clk);
            if (bus.out_valid) break;
            t++;
        end
        if (t >= 100) check("valid_timeout", t, 0);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int out0;
        int acc;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        for (int i = 0; i < 16; i++) tab[i] = 8'(16 * i);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_lut_address", int'(bus.lut_address), 0);
        @(posedge clk);
        #1;

        // Pin the model with hand-computed values on the identity table
        check("model_37", model_y(8'd37), 37);
        check("model_127", model_y(8'd127), 112);
        check("model_m1", model_y(8'hFF), -1);

        // Latency: x = 37 appears after exactly three more edges
        send(8'd37, w);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("lat_not_yet", int'(bus.out_valid), 0);
        end
        @(negedge clk);
        check("lat_valid", int'(bus.out_valid), 1);
        check("lat_data", int'(bus.out_data), 37);
        drain();

        // Segment 7 (next = base) and segment 15 (wrap) back to back
        send(8'd127, w);
        send(8'hFF, w);
        wait_valid();
        check("b2b_first", int'(bus.out_data), 112);
        @(negedge clk);
        check("b2b_second_valid", int'(bus.out_valid), 1);
        check("b2b_second", int'(bus.out_data), -1);
        drain();

        // Rounding behaviour with the fixed-reply table, frac = 14
        tab_mode = 1;
`ifdef NN_PWL_ROUND_EN
        check("model_round", model_y(8'h0E), 13);
`else
        check("model_round", model_y(8'h0E), 12);
`endif
        send(8'h0E, w);
        wait_valid();
`ifdef NN_PWL_ROUND_EN
        check("round_out", int'(bus.out_data), 13);
`else
        check("round_out", int'(bus.out_data), 12);
`endif
        drain();
        tab_mode = 0;

        // Full throughput: no sample may wait while the consumer is always ready
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            send(8'($urandom), w);
            acc += w;
        end
        check("no_stall_stream", acc, 0);
        drain();

        // Backpressure: fill the pipe with the consumer blocked
        or_mode = 2;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) send(8'(i * 19 + 3), w);
        @(negedge clk);
        check("full_in_ready", int'(bus.in_ready), 0);
        check("full_out_valid", int'(bus.out_valid), 1);
        @(posedge clk);
        #1;
        out0 = n_out;
        or_mode = 1;
        for (int i = 0; i < 8; i++) send(8'($urandom), w);
        drain();
        check("bp_count", n_out - out0, 12);
        or_mode = 0;

        // Reset with samples in flight
        or_mode = 2;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(8'(i * 40 + 7), w);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", int'(bus.out_valid), 0);
        check("mid_rst_in_ready", int'(bus.in_ready), 1);
        check("mid_rst_lut_address", int'(bus.lut_address), 0);
        or_mode = 0;
        stale_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) stale_seen++;
        end
        check("no_stale_after_rst", stale_seen, 0);
        @(posedge clk);
        #1;
        send(8'd37, w);
        wait_valid();
        check("post_rst_data", int'(bus.out_data), 37);
        drain();

        // Randomized table, samples, gaps and backpressure
        for (int i = 0; i < 16; i++) tab[i] = 8'($urandom);
        out0 = n_out;
        or_mode = 3;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(8'($urandom), w);
        end
        drain();
        check("rand_count", n_out - out0, 300);
        or_mode = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
